// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/sequencing controller.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 16;

  // Latch controls, grouped so every rule can assign all of them in one statement.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_JUMP   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/sequencing controller.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             jump_ex;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           jump_ex, branch_taken, mem_req, mem_ack,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, mem_err, stall_cycles
  );

  modport slave (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           jump_ex, branch_taken, mem_req, mem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       load_use
);

  logic rs_hit_s;
  logic rt_hit_s;

  assign rs_hit_s = (idex_rt == ifid_rs);
  assign rt_hit_s = ifid_uses_rt && (idex_rt == ifid_rt);

  // $0 is hardwired, so a load targeting it can never create a real dependency.
  assign load_use = idex_memread && (idex_rt != REG_ZERO) && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: memory freeze,
// branch/jump squash, load-use bubble, stall accounting and memory timeout.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.master  pl
);

  localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_e            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic  load_use_s;
  logic  freeze_s;
  logic  timeout_s;
  ctrl_t ctrl_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  hazard_detect u_hazard_detect (
    .idex_memread (pl.idex_memread),
    .idex_rt      (pl.idex_rt),
    .ifid_rs      (pl.ifid_rs),
    .ifid_rt      (pl.ifid_rt),
    .ifid_uses_rt (pl.ifid_uses_rt),
    .load_use     (load_use_s)
  );

  // Once wait_cnt reaches the limit the freeze term drops, which is the forced release.
  assign freeze_s  = pl.mem_req && !pl.mem_ack && (wait_cnt_r < TIMEOUT_CNT);
  assign timeout_s = (state_r == MEM_WAIT) && (wait_cnt_r == TIMEOUT_CNT) && !pl.mem_ack;

  // Priority-ordered latch control selection.
  always_comb begin
    ctrl_s = CTRL_RUN;
    if (!rst) begin
      ctrl_s = CTRL_RESET;
    end else if (freeze_s) begin
      ctrl_s = CTRL_FREEZE;
    end else if (pl.branch_taken) begin
      ctrl_s = CTRL_BRANCH;
    end else if (pl.jump_ex) begin
      ctrl_s = CTRL_JUMP;
    end else if (load_use_s) begin
      ctrl_s = CTRL_STALL;
    end else begin
      ctrl_s = CTRL_RUN;
    end
  end

  // Sequencing state, wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (freeze_s) begin
        state_r    <= MEM_WAIT;
        wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
        state_r    <= RUN;
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end
      if (!ctrl_s.pc_write) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
    end
  end

  assign pl.pc_write     = ctrl_s.pc_write;
  assign pl.ifid_write   = ctrl_s.ifid_write;
  assign pl.ifid_flush   = ctrl_s.ifid_flush;
  assign pl.idex_write   = ctrl_s.idex_write;
  assign pl.idex_flush   = ctrl_s.idex_flush;
  assign pl.exmem_write  = ctrl_s.exmem_write;
  assign pl.exmem_flush  = ctrl_s.exmem_flush;
  assign pl.mem_err      = mem_err_r;
  assign pl.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a cycle-level reference model queues the
// expected controls per stimulus cycle; a negedge monitor pops and compares.
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  localparam int CW  = 6;
  localparam int TO  = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) pl ();

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .pl  (pl)
  );

  typedef struct {
    string          tag;
    logic [6:0]     ctrl;
    logic           err;
    logic [CW-1:0]  stalls;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: cycles spent waiting on the current access, sticky error, stalls.
  int m_waited = 0;
  bit m_err    = 1'b0;
  int m_stalls = 0;

  logic       s_rst, s_memread, s_uses_rt, s_jump, s_branch, s_req, s_ack;
  logic [4:0] s_idex_rt, s_rs, s_rt;

  task automatic clear_stim();
    s_rst = 1'b1; s_memread = 1'b0; s_uses_rt = 1'b0; s_jump = 1'b0;
    s_branch = 1'b0; s_req = 1'b0; s_ack = 1'b0;
    s_idex_rt = 5'd0; s_rs = 5'd0; s_rt = 5'd0;
  endtask

  task automatic rand_stim();
    s_memread = 1'($urandom_range(0, 1));
    s_uses_rt = 1'($urandom_range(0, 1));
    s_jump    = ($urandom_range(0, 7) == 0);
    s_branch  = ($urandom_range(0, 7) == 0);
    s_idex_rt = 5'($urandom_range(0, 3));
    s_rs      = 5'($urandom_range(0, 3));
    s_rt      = 5'($urandom_range(0, 3));
  endtask

  task automatic model_eval(input string tag);
    logic [6:0] c;
    bit frozen, lu;
    if (!s_rst) begin
      m_waited = 0; m_err = 1'b0; m_stalls = 0;
      sb.push_back('{tag, 7'b0010101, 1'b0, {CW{1'b0}}});
      return;
    end
    lu = s_memread && (s_idex_rt != 5'd0) &&
         ((s_idex_rt == s_rs) || (s_uses_rt && (s_idex_rt == s_rt)));
    frozen = s_req && !s_ack && (m_waited < TO);
    if (frozen)        c = 7'b0000000;
    else if (s_branch) c = 7'b1111111;
    else if (s_jump)   c = 7'b1111110;
    else if (lu)       c = 7'b0001110;
    else               c = 7'b1101010;
    sb.push_back('{tag, c, m_err, m_stalls[CW-1:0]});
    if (!frozen && (m_waited == TO) && !s_ack) m_err = 1'b1;
    m_waited = frozen ? m_waited + 1 : 0;
    if (!c[6]) m_stalls = (m_stalls < MAXC) ? m_stalls + 1 : MAXC;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    rst              = s_rst;
    pl.idex_memread  = s_memread;
    pl.idex_rt       = s_idex_rt;
    pl.ifid_rs       = s_rs;
    pl.ifid_rt       = s_rt;
    pl.ifid_uses_rt  = s_uses_rt;
    pl.jump_ex       = s_jump;
    pl.branch_taken  = s_branch;
    pl.mem_req       = s_req;
    pl.mem_ack       = s_ack;
    model_eval(tag);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rand_stim();
      s_req = 1'($urandom_range(0, 1));
      s_ack = 1'($urandom_range(0, 1));
      s_rst = 1'b0;
      step("reset");
    end
    clear_stim();
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [6:0] act;
      e = sb.pop_front();
      act = {pl.pc_write, pl.ifid_write, pl.ifid_flush, pl.idex_write,
             pl.idex_flush, pl.exmem_write, pl.exmem_flush};
      n_cmp++;
      if (act !== e.ctrl || pl.mem_err !== e.err || pl.stall_cycles !== e.stalls) begin
        n_bad++;
        $display("FAIL %s @%0t: ctrl=%b err=%b stalls=%0d, expected ctrl=%b err=%b stalls=%0d",
                 e.tag, $time, act, pl.mem_err, pl.stall_cycles, e.ctrl, e.err, e.stalls);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    pl.idex_memread = 1'b0; pl.idex_rt = 5'd0; pl.ifid_rs = 5'd0; pl.ifid_rt = 5'd0;
    pl.ifid_uses_rt = 1'b0; pl.jump_ex = 1'b0; pl.branch_taken = 1'b0;
    pl.mem_req = 1'b0; pl.mem_ack = 1'b0;
    clear_stim();

    do_reset(3);
    step("idle");

    // Load-use through rs, then the bubble has gone and the pipe runs clean.
    s_memread = 1'b1; s_idex_rt = 5'd8; s_rs = 5'd8; step("loaduse_rs");
    clear_stim(); step("after_loaduse");
    s_memread = 1'b1; s_idex_rt = 5'd0; s_rs = 5'd0; step("loaduse_r0");
    s_memread = 1'b1; s_idex_rt = 5'd5; s_rs = 5'd1; s_rt = 5'd5; s_uses_rt = 1'b1;
    step("loaduse_rt");
    s_uses_rt = 1'b0; step("rt_not_used");
    clear_stim();

    // Branch squashes the dependent instruction; jump keeps EX/MEM.
    s_branch = 1'b1; s_memread = 1'b1; s_idex_rt = 5'd9; s_rs = 5'd9; step("branch_lu");
    clear_stim(); s_jump = 1'b1; step("jump");
    clear_stim(); step("idle2");

    // Four frozen cycles, branch held off until the ack cycle.
    do_reset(1);
    s_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_branch = (i == 2);
      step("mem_wait");
    end
    s_branch = 1'b1; s_ack = 1'b1; step("mem_ack_branch");
    clear_stim(); step("after_ack");

    // Timeout: 16 frozen, release on the 17th, error stays sticky.
    do_reset(1);
    s_req = 1'b1;
    for (int i = 0; i < TO + 1; i++) step("timeout");
    clear_stim(); step("after_timeout");
    s_req = 1'b1; step("later_wait");
    s_ack = 1'b1; step("later_ack");
    clear_stim(); step("err_sticky");

    // Reset in the middle of a wait.
    do_reset(1);
    s_req = 1'b1;
    for (int i = 0; i < 3; i++) step("pre_reset_wait");
    s_rst = 1'b0; step("reset_mid_wait");
    clear_stim(); step("post_reset");
    step("post_reset2");

    // Randomized traffic, including long waits and occasional resets.
    for (int i = 0; i < 700; i++) begin
      rand_stim();
      s_rst = ($urandom_range(0, 199) != 0);
      s_req = ($urandom_range(0, 2) != 0);
      s_ack = (i % 120 < 60) ? ($urandom_range(0, 2) == 0) : 1'b0;
      step("random");
    end

    clear_stim();
    step("drain");
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives write-enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM latches.
- Detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and freezes the whole pipeline while data memory has not acknowledged.
- Counts stall cycles and flags memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ack before forced release.
- CNT_W, 32: width of the stall_cycles counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- idex_memread  in  1  the ID/EX instruction is a load.
- idex_rt  in  5  destination (rt) field of the ID/EX instruction.
- ifid_rs  in  5  rs field of the instruction in ID.
- ifid_rt  in  5  rt field of the instruction in ID.
- ifid_uses_rt  in  1  the ID instruction reads rt as a source.
- jump_ex  in  1  jump_out of ID/EX; jump resolved in EX.
- branch_taken  in  1  branch resolved taken in MEM.
- mem_req  in  1  MEM stage is issuing a load or store.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads zeroed controls (bubble).
- exmem_write  out  1  EX/MEM load enable.
- exmem_flush  out  1  EX/MEM loads zeroed controls.
- mem_err  out  1  sticky: a memory timeout occurred.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
  - While rst=0, all write enables are forced to 0 and all flushes to 1, so latches load bubbles.
- Control outputs are combinational from the current state and inputs. Only the state, wait_cnt, mem_err and stall_cycles are registered.
- States: RUN, MEM_WAIT.
- Priority is evaluated every cycle, highest first.
  1. Memory freeze: mem_req=1, mem_ack=0 and wait_cnt<MEM_TIMEOUT.
     - All write enables 0, all flushes 0.
     - Next state MEM_WAIT; wait_cnt+1.
  2. Branch flush: branch_taken=1.
     - ifid_flush=idex_flush=exmem_flush=1.
     - All write enables 1 (PC loads the target).
  3. Jump flush: jump_ex=1.
     - ifid_flush=idex_flush=1, exmem_flush=0.
     - All write enables 1.
  4. Load-use stall: idex_memread=1, idex_rt!=0, and (idex_rt==ifid_rs, or ifid_uses_rt=1 and idex_rt==ifid_rt).
     - pc_write=ifid_write=0; idex_flush=1; idex_write=exmem_write=1.
     - Exactly one bubble is inserted; the load advances, so the next cycle re-evaluates clean.
  5. Otherwise: all write enables 1, all flushes 0.
- MEM_WAIT → RUN on the cycle mem_ack=1.
  - That cycle is not frozen; rules 2–5 apply to the same inputs.
  - wait_cnt clears to 0.
- Timeout:
  - In MEM_WAIT with wait_cnt==MEM_TIMEOUT and mem_ack=0, the access is treated as acknowledged.
  - mem_err is set to 1 and stays sticky until reset.
  - State returns to RUN and wait_cnt clears.
- Simultaneous events:
  - Branch and load-use in the same cycle: the branch flush wins; no stall is applied because the ID instruction is squashed.
  - Branch or jump during a freeze: held off until release, then applied on the release cycle.
- stall_cycles increments on every cycle with pc_write=0 and rst=1. It saturates at all-ones and never wraps.
- Register $0 never triggers a load-use stall.
- Reset asserted mid-MEM_WAIT: immediate return to the reset values above.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding RUN=1'b0, MEM_WAIT=1'b1;
  - REG_ZERO=5'd0;
  - the default MEM_TIMEOUT constant.
- One natural sub-module, hazard_detect: purely combinational load-use comparator producing load_use. All sequencing stays in pipeline_ctrl.

Test Plan:
- Reset: rst=0 for 3 cycles with random inputs → all write enables 0, all flushes 1, stall_cycles=0, mem_err=0.
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 → exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1. With idex_rt=0 → no stall.
- Branch plus load-use in the same cycle (branch_taken=1, idex_memread=1, idex_rt=ifid_rs=9) → all three flushes 1, pc_write=1, no stall counted.
- Memory wait: mem_req=1, mem_ack low for 4 cycles then high → 4 frozen cycles (all enables 0), advance on the ack cycle, stall_cycles=4, mem_err=0.
- Timeout with MEM_TIMEOUT=16: mem_req=1 and mem_ack never asserted → 16 frozen cycles, release on the 17th, mem_err=1 and held; a later normal ack leaves mem_err=1.
- Reset mid-wait: rst pulled low after 3 frozen cycles → asynchronous return to RUN; wait_cnt=0 and stall_cycles=0 after release.
